// File: rtl/alu_psw_commit.sv
// ALU writeback/PSW commit stage: registers one ALU result per cycle, merges byte ops,
// applies the masked PSW flag update and counts retired instructions.
module alu_psw_commit #(
    parameter logic [15:0] PSW_RESET = 16'h0000,
    parameter int          REG_AW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [15:0]       ex_result,
    input  logic [15:0]       ex_psw_out,
    input  logic [15:0]       ex_psw_msk,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_wr_en,
    input  logic              ex_byte,
    input  logic [15:0]       ex_old_dst,
    input  logic              stall,
    input  logic              flush,
    input  logic              psw_ld_en,
    input  logic [15:0]       psw_ld_data,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_dst,
    output logic [15:0]       wb_data,
    output logic [15:0]       psw,
    output logic              carry_flag,
    output logic [15:0]       retire_cnt
);

    localparam int DATA_W = 16;

    logic acc_p0;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic              is_byte,
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] res
    );
        return is_byte ? {old_val[DATA_W-1:8], res[7:0]} : res;
    endfunction

    function automatic logic [DATA_W-1:0] psw_apply(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] flags,
        input logic [DATA_W-1:0] msk
    );
        return (cur & ~msk) | (flags & msk);
    endfunction

    assign acc_p0 = ex_valid & ~stall & ~flush;

    // execute -> writeback boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_dst     <= '0;
            wb_data    <= '0;
            psw        <= PSW_RESET;
            retire_cnt <= '0;
        end else begin
            if (flush) begin
                wb_valid <= 1'b0;
                wb_we    <= 1'b0;
            end else if (!stall) begin
                wb_valid <= ex_valid;
                wb_we    <= ex_valid & ex_wr_en;
                if (ex_valid) begin
                    wb_dst     <= ex_dst;
                    wb_data    <= byte_merge(ex_byte, ex_old_dst, ex_result);
                    retire_cnt <= retire_cnt + 16'd1;
                end
            end

            // An explicit load always beats the instruction's flag update
            if (psw_ld_en)
                psw <= psw_ld_data;
            else if (acc_p0)
                psw <= psw_apply(psw, ex_psw_out, ex_psw_msk);
        end
    end

    assign carry_flag = psw[0];

endmodule

// File: tb/tb_alu_psw_commit.sv
// Self-checking bench for alu_psw_commit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_alu_psw_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_result;
    logic [15:0] ex_psw_out;
    logic [15:0] ex_psw_msk;
    logic [2:0]  ex_dst;
    logic        ex_wr_en;
    logic        ex_byte;
    logic [15:0] ex_old_dst;
    logic        stall;
    logic        flush;
    logic        psw_ld_en;
    logic [15:0] psw_ld_data;
    logic        wb_valid;
    logic        wb_we;
    logic [2:0]  wb_dst;
    logic [15:0] wb_data;
    logic [15:0] psw;
    logic        carry_flag;
    logic [15:0] retire_cnt;

    int n_chk = 0;
    int n_err = 0;

    // reference state
    logic        m_valid, m_we;
    logic [2:0]  m_dst;
    logic [15:0] m_data, m_psw;
    int          m_cnt;

    alu_psw_commit #(.PSW_RESET(16'h0000), .REG_AW(3)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_psw_out(ex_psw_out),
        .ex_psw_msk(ex_psw_msk), .ex_dst(ex_dst), .ex_wr_en(ex_wr_en),
        .ex_byte(ex_byte), .ex_old_dst(ex_old_dst), .stall(stall), .flush(flush),
        .psw_ld_en(psw_ld_en), .psw_ld_data(psw_ld_data),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .psw(psw), .carry_flag(carry_flag), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Next-state of the stage, written from the behaviour rules with plain arithmetic
    task automatic model_edge();
        bit take;
        if (rst) begin
            m_valid = 0; m_we = 0; m_dst = 0; m_data = 0; m_psw = 16'h0000; m_cnt = 0;
            return;
        end
        take = ex_valid && !stall && !flush;
        if (flush) begin
            m_valid = 0; m_we = 0;
        end else if (!stall) begin
            if (ex_valid) begin
                m_valid = 1;
                m_we    = ex_wr_en;
                m_dst   = ex_dst;
                m_data  = ex_byte ? (ex_old_dst / 256) * 256 + (ex_result % 256) : ex_result;
                m_cnt   = (m_cnt + 1) % 65536;
            end else begin
                m_valid = 0; m_we = 0;
            end
        end
        if (psw_ld_en)
            m_psw = psw_ld_data;
        else if (take)
            for (int i = 0; i < 16; i++)
                if (ex_psw_msk[i]) m_psw[i] = ex_psw_out[i];
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".wb_valid"}, 32'(wb_valid), 32'(m_valid));
        chk({ctx, ".wb_we"}, 32'(wb_we), 32'(m_we));
        chk({ctx, ".wb_dst"}, 32'(wb_dst), 32'(m_dst));
        chk({ctx, ".wb_data"}, 32'(wb_data), 32'(m_data));
        chk({ctx, ".psw"}, 32'(psw), 32'(m_psw));
        chk({ctx, ".carry"}, 32'(carry_flag), 32'(m_psw[0]));
        chk({ctx, ".retire_cnt"}, 32'(retire_cnt), 32'(m_cnt));
    endtask

    task automatic step(input string ctx, input bit do_chk);
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) check_all(ctx);
    endtask

    task automatic set_ex(input logic v, input logic [15:0] res, input logic [15:0] pout,
                          input logic [15:0] msk, input logic [2:0] dst, input logic we,
                          input logic byt, input logic [15:0] old);
        ex_valid = v; ex_result = res; ex_psw_out = pout; ex_psw_msk = msk;
        ex_dst = dst; ex_wr_en = we; ex_byte = byt; ex_old_dst = old;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; psw_ld_en = 0; psw_ld_data = 0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        m_valid = 0; m_we = 0; m_dst = 0; m_data = 0; m_psw = 0; m_cnt = 0;

        step("reset", 1);
        chk("reset.wb_valid", 32'(wb_valid), 32'h0);
        chk("reset.psw", 32'(psw), 32'h0000);
        chk("reset.retire_cnt", 32'(retire_cnt), 32'h0);
        rst = 0;

        set_ex(1, 16'h1234, 16'h0000, 16'h0017, 3'd1, 1, 0, 16'h0000);
        step("add", 1);
        chk("add.wb_valid", 32'(wb_valid), 32'h1);
        chk("add.wb_we", 32'(wb_we), 32'h1);
        chk("add.wb_dst", 32'(wb_dst), 32'h1);
        chk("add.wb_data", 32'(wb_data), 32'h1234);
        chk("add.retire_cnt", 32'(retire_cnt), 32'h1);

        set_ex(1, 16'h0000, 16'h0003, 16'h001F, 3'd2, 1, 0, 16'h0000);
        step("chain0", 1);
        chk("chain0.carry", 32'(carry_flag), 32'h1);
        chk("chain0.psw", 32'(psw), 32'h0003);
        set_ex(1, 16'h0001, 16'h0000, 16'h001F, 3'd3, 1, 0, 16'h0000);
        step("chain1", 1);
        chk("chain1.psw", 32'(psw), 32'h0000);
        chk("chain1.carry", 32'(carry_flag), 32'h0);

        set_ex(1, 16'h12CD, 16'h0000, 16'h0000, 3'd4, 1, 1, 16'hAB00);
        step("byte", 1);
        chk("byte.wb_data", 32'(wb_data), 32'hABCD);
        chk("byte.retire_cnt", 32'(retire_cnt), 32'h4);

        set_ex(1, 16'h7777, 16'h5555, 16'hFFFF, 3'd5, 1, 0, 16'h0000);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step("stall", 1);
            chk("stall.wb_data", 32'(wb_data), 32'hABCD);
            chk("stall.psw", 32'(psw), 32'h0000);
            chk("stall.retire_cnt", 32'(retire_cnt), 32'h4);
        end
        stall = 0;
        step("release", 1);
        chk("release.retire_cnt", 32'(retire_cnt), 32'h5);
        chk("release.psw", 32'(psw), 32'h5555);
        chk("release.wb_data", 32'(wb_data), 32'h7777);
        set_ex(1, 16'h1111, 16'h0000, 16'hFFFF, 3'd6, 1, 0, 16'h0000);
        stall = 1; flush = 1;
        step("stallflush", 1);
        chk("stallflush.wb_valid", 32'(wb_valid), 32'h0);
        chk("stallflush.psw", 32'(psw), 32'h5555);
        stall = 0; flush = 0;

        set_ex(1, 16'h4242, 16'h001F, 16'h001F, 3'd7, 1, 0, 16'h0000);
        psw_ld_en = 1; psw_ld_data = 16'h60E0;
        step("pswld", 1);
        chk("pswld.psw", 32'(psw), 32'h60E0);
        chk("pswld.wb_valid", 32'(wb_valid), 32'h1);
        chk("pswld.wb_data", 32'(wb_data), 32'h4242);
        chk("pswld.retire_cnt", 32'(retire_cnt), 32'h6);
        psw_ld_en = 0;

        rst = 1;
        step("rst2", 1);
        rst = 0;
        set_ex(1, 16'h0101, 16'h0000, 16'h0000, 3'd1, 1, 0, 16'h0000);
        for (int i = 0; i < 65535; i++) step("fill", 0);
        chk("fill.retire_cnt", 32'(retire_cnt), 32'hFFFF);
        step("wrap", 1);
        chk("wrap.retire_cnt", 32'(retire_cnt), 32'h0000);

        set_ex(1, 16'h9999, 16'hFFFF, 16'hFFFF, 3'd3, 1, 0, 16'h0000);
        step("pre_rst", 1);
        stall = 1; rst = 1;
        step("rst_stall", 1);
        chk("rst_stall.wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_stall.wb_data", 32'(wb_data), 32'h0);
        chk("rst_stall.psw", 32'(psw), 32'h0000);
        chk("rst_stall.retire_cnt", 32'(retire_cnt), 32'h0);
        rst = 0; stall = 0;

        for (int i = 0; i < 2000; i++) begin
            set_ex(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                   16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            psw_ld_en   = ($urandom_range(0, 9) == 0);
            psw_ld_data = 16'($urandom);
            rst         = ($urandom_range(0, 63) == 0);
            step("rand", 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_psw_commit.md
Name: alu_psw_commit

Overview:
- Pipeline register and PSW commit stage directly downstream of the ALU operation units (ADDC and siblings).
- Each clock it captures one ALU result, merges the result for byte operations, and presents a registered register-file writeback.
- Applies the unit's masked PSW flag update (psw_out/psw_msk) to the architectural PSW.
- Drives carry_flag back to the ALU's carry_in for the next instruction.

Parameters:
- PSW_RESET, 16'h0000, PSW value loaded on reset.
- REG_AW, 3, register-file address width (R0-R7).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- ex_valid  in  1  ALU output this cycle is a real instruction.
- ex_result  in  16  ALU result.
- ex_psw_out  in  16  new PSW flag values from ALU.
- ex_psw_msk  in  16  1 = PSW bit is updated by this instruction.
- ex_dst  in  REG_AW  destination register.
- ex_wr_en  in  1  instruction writes ex_dst.
- ex_byte  in  1  byte operation; only the low byte of the destination changes.
- ex_old_dst  in  16  current destination register contents, used for the byte merge.
- stall  in  1  hold stage contents.
- flush  in  1  squash the incoming instruction.
- psw_ld_en  in  1  explicit PSW load (exception entry/return).
- psw_ld_data  in  16  PSW value for explicit load.
- wb_valid  out  1  registered instruction valid.
- wb_we  out  1  register-file write enable.
- wb_dst  out  REG_AW  register-file write address.
- wb_data  out  16  register-file write data.
- psw  out  16  architectural PSW.
- carry_flag  out  1  psw[0], to ALU carry_in.
- retire_cnt  out  16  committed-instruction counter.

Behaviour:
- All state updates on the rising clk edge. Outputs are registered; carry_flag is a combinational alias of psw[0].
- Reset (rst=1 at the edge) overrides everything: wb_valid=0, wb_we=0, wb_dst=0, wb_data=0, psw=PSW_RESET, retire_cnt=0.
- Accept condition: acc = ex_valid & ~stall & ~flush.
- Priority, highest first: rst, then flush, then stall, then normal.
- flush=1: wb_valid<=0, wb_we<=0; wb_dst/wb_data unchanged; no PSW flag update; retire_cnt unchanged. Flush wins over simultaneous stall.
- stall=1 (no flush): wb_valid, wb_we, wb_dst, wb_data, retire_cnt and PSW flag state all hold.
- Normal, acc=1:
  - wb_valid<=1; wb_we<=ex_wr_en; wb_dst<=ex_dst.
  - wb_data<= ex_byte ? {ex_old_dst[15:8], ex_result[7:0]} : ex_result.
  - psw <= (psw & ~ex_psw_msk) | (ex_psw_out & ex_psw_msk).
  - retire_cnt<=retire_cnt+1, wrapping 16'hFFFF -> 16'h0000.
- Normal, ex_valid=0: wb_valid<=0, wb_we<=0, psw holds.
- psw_ld_en=1 (no rst): psw<=psw_ld_data, overriding any flag update the same cycle, including during stall or flush. The wb_* and retire_cnt fields follow the rules above independently.
- Latency: one cycle from ALU output to wb_* and psw. An instruction in execute at cycle N+1 sees flags from cycle N through carry_flag, so back-to-back ADDC chains need no extra forwarding.
- Mask bits of 0 never alter psw. A mask of 16'h0000 with acc=1 still commits the writeback and increments retire_cnt.
- Reset asserted mid-stall or mid-flush clears state on that edge. First acceptance is possible on the edge after rst deasserts.

Test Plan:
- Reset, then ADD R1: ex_result=16'h1234, msk=16'h0017, psw_out=16'h0000 -> next cycle wb_valid=1, wb_we=1, wb_dst=1, wb_data=16'h1234, psw=16'h0000, retire_cnt=1.
- Carry chain: cycle0 ex_result=16'h0000, psw_out=16'h0003, msk=16'h001F; cycle1 observe carry_flag=1 and psw=16'h0003; cycle1 ex_result=16'h0001, psw_out=0, msk=16'h001F -> cycle2 psw=16'h0000, carry_flag=0.
- Byte merge: ex_byte=1, ex_old_dst=16'hAB00, ex_result=16'h12CD -> wb_data=16'hABCD.
- Stall 3 cycles with ex_valid=1, msk=16'hFFFF -> wb_*, psw and retire_cnt frozen; release -> single commit, retire_cnt +1. Stall and flush together -> wb_valid=0, psw unchanged.
- psw_ld_en=1, psw_ld_data=16'h60E0 same cycle as acc with msk=16'h001F, psw_out=16'h001F -> psw=16'h60E0 and the writeback still commits.
- retire_cnt preloaded to 16'hFFFF by 65535 commits, one more commit -> 16'h0000; rst asserted during a stall -> all outputs return to reset values on that edge.
